vx_scoreboard: RTL and testbench



---
 rtl/vx_scoreboard_if.sv | 48 ++++
 rtl/vx_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_vx_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_scoreboard_if.sv
// vx_scoreboard_if: decode / writeback / status bundle of the per-warp load
// scoreboard.
//   master : decode stage side (drives decode + writeback, observes status)
//   slave  : scoreboard side
// Signals:
//   in_decode_*        instruction currently held in decode
//   in_ext_stall       other stall sources (forwarding stall included)
//   in_wb_*            load writeback (warp, register)
//   out_stall          decode must hold (combinational)
//   out_fence_done/_warp  one-cycle fence completion pulse and its warp
//   out_wb_err         writeback hit a non-pending register
//   out_warp_busy      per-warp "has outstanding loads"
interface vx_scoreboard_if #(
  parameter int NW = 8
);
  localparam int NWB = (NW > 1) ? $clog2(NW) : 1;

  logic           in_decode_valid;
  logic [NWB-1:0] in_decode_warp_num;
  logic [4:0]     in_decode_src1;
  logic [4:0]     in_decode_src2;
  logic [4:0]     in_decode_dest;
  logic [1:0]     in_decode_wb;
  logic           in_decode_is_fence;
  logic           in_ext_stall;
  logic           in_wb_valid;
  logic [NWB-1:0] in_wb_warp_num;
  logic [4:0]     in_wb_dest;
  logic           out_stall;
  logic           out_fence_done;
  logic [NWB-1:0] out_fence_warp;
  logic           out_wb_err;
  logic [NW-1:0]  out_warp_busy;

  modport master (
    output in_decode_valid, in_decode_warp_num, in_decode_src1, in_decode_src2,
           in_decode_dest, in_decode_wb, in_decode_is_fence, in_ext_stall,
           in_wb_valid, in_wb_warp_num, in_wb_dest,
    input  out_stall, out_fence_done, out_fence_warp, out_wb_err, out_warp_busy
  );

  modport slave (
    input  in_decode_valid, in_decode_warp_num, in_decode_src1, in_decode_src2,
           in_decode_dest, in_decode_wb, in_decode_is_fence, in_ext_stall,
           in_wb_valid, in_wb_warp_num, in_wb_dest,
    output out_stall, out_fence_done, out_fence_warp, out_wb_err, out_warp_busy
  );
endinterface

// File: rtl/vx_scoreboard.sv
// vx_scoreboard: per-warp register scoreboard for in-flight loads plus a
// fence sequencer that waits for a warp's outstanding loads to drain.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   sb     : vx_scoreboard_if.slave (decode, writeback, status outputs)
// out_stall is combinational from decode inputs and registered state; all
// other outputs are registered.
module vx_scoreboard #(
  parameter int NW    = 8,
  parameter int CNT_W = 5
) (
  input logic           clk,
  input logic           reset,
  vx_scoreboard_if.slave sb
);
  localparam int NWB = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [1:0]       NO_WB    = 2'd0;
  localparam logic [1:0]       WB_MEM   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NW-1:0]    NW_ONE   = NW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } fence_state_t;

  logic [31:0]      r_pending [NW];
  logic [CNT_W-1:0] r_count   [NW];
  logic [CNT_W-1:0] w_count_nxt [NW];
  fence_state_t     r_state;
  fence_state_t     w_state_nxt;
  logic [NWB-1:0]   r_fence_warp;
  logic [NWB-1:0]   w_fence_warp_nxt;
  logic             r_fence_done;
  logic             r_wb_err;
  logic [NW-1:0]    r_busy;

  logic [31:0]      w_dec_pend;
  logic             w_raw;
  logic             w_waw;
  logic             w_ovf;
  logic             w_fence_blk;
  logic             w_stall;
  logic             w_issue;
  logic             w_set;
  logic             w_wb_hit;
  logic             w_fence_issue;
  logic [NW-1:0]    w_inc_vec;
  logic [NW-1:0]    w_dec_vec;

  // Hazard detection against the decode warp's registered pending state.
  // x0 is never pending, so the nonzero guards only keep x0 out explicitly.
  assign w_dec_pend  = r_pending[sb.in_decode_warp_num];
  assign w_raw       = ((sb.in_decode_src1 != 5'd0) && w_dec_pend[sb.in_decode_src1]) ||
                       ((sb.in_decode_src2 != 5'd0) && w_dec_pend[sb.in_decode_src2]);
  assign w_waw       = (sb.in_decode_wb != NO_WB) && (sb.in_decode_dest != 5'd0) &&
                       w_dec_pend[sb.in_decode_dest];
  assign w_ovf       = (sb.in_decode_wb == WB_MEM) &&
                       (r_count[sb.in_decode_warp_num] == CNT_MAX);
  // Only DRAIN blocks: in DONE the sequencer is retiring and can accept the
  // next fence in the same cycle, so a held fence issues with the done pulse.
  assign w_fence_blk = (r_state == S_DRAIN) &&
                       ((sb.in_decode_warp_num == r_fence_warp) || sb.in_decode_is_fence);
  assign w_stall     = sb.in_decode_valid & (w_raw | w_waw | w_ovf | w_fence_blk);
  assign w_issue     = sb.in_decode_valid & ~w_stall & ~sb.in_ext_stall;

  assign w_set         = w_issue && (sb.in_decode_wb == WB_MEM) && (sb.in_decode_dest != 5'd0);
  assign w_wb_hit      = sb.in_wb_valid && r_pending[sb.in_wb_warp_num][sb.in_wb_dest];
  assign w_fence_issue = w_issue && sb.in_decode_is_fence;

  assign w_inc_vec = w_set    ? (NW_ONE << sb.in_decode_warp_num) : {NW{1'b0}};
  assign w_dec_vec = w_wb_hit ? (NW_ONE << sb.in_wb_warp_num)     : {NW{1'b0}};

  // Next outstanding-load count per warp; a simultaneous inc/dec cancels.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      w_count_nxt[w] = r_count[w];
      if (w_inc_vec[w] && !w_dec_vec[w]) begin
        w_count_nxt[w] = r_count[w] + CNT_ONE;
      end else if (!w_inc_vec[w] && w_dec_vec[w]) begin
        w_count_nxt[w] = r_count[w] - CNT_ONE;
      end else begin
        w_count_nxt[w] = r_count[w];
      end
    end
  end

  // Fence sequencer next state. DRAIN leaves as soon as the warp's count is
  // going to zero this cycle, so DONE lines up with the cycle after the last
  // writeback.
  always_comb begin
    w_state_nxt      = r_state;
    w_fence_warp_nxt = r_fence_warp;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_fence_issue) begin
          w_fence_warp_nxt = sb.in_decode_warp_num;
          if (r_count[sb.in_decode_warp_num] == CNT_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_count_nxt[r_fence_warp] == CNT_ZERO) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pending bits and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        r_pending[w] <= 32'h0000_0000;
        r_count[w]   <= CNT_ZERO;
      end
    end else begin
      if (w_set) begin
        r_pending[sb.in_decode_warp_num][sb.in_decode_dest] <= 1'b1;
      end
      if (w_wb_hit) begin
        r_pending[sb.in_wb_warp_num][sb.in_wb_dest] <= 1'b0;
      end
      for (int w = 0; w < NW; w++) begin
        r_count[w] <= w_count_nxt[w];
      end
    end
  end

  // Fence state register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fence_warp <= {NWB{1'b0}};
      r_fence_done <= 1'b0;
      r_wb_err     <= 1'b0;
      r_busy       <= {NW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_fence_warp <= w_fence_warp_nxt;
      r_fence_done <= (w_state_nxt == S_DONE);
      r_wb_err     <= sb.in_wb_valid && !w_wb_hit;
      for (int w = 0; w < NW; w++) begin
        r_busy[w] <= (w_count_nxt[w] != CNT_ZERO);
      end
    end
  end

  assign sb.out_stall      = w_stall;
  assign sb.out_fence_done = r_fence_done;
  assign sb.out_fence_warp = r_fence_warp;
  assign sb.out_wb_err     = r_wb_err;
  assign sb.out_warp_busy  = r_busy;
endmodule

// File: tb/tb_vx_scoreboard.sv
module tb_vx_scoreboard;
  localparam int NW     = 8;
  localparam int NWB    = 3;
  localparam int CNT_W  = 2;
  localparam int MAXCNT = (1 << CNT_W) - 1;
  localparam int NO_WB = 0, ALU = 1, MEM = 2, JAL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_scoreboard_if #(.NW(NW)) sbif ();
  vx_scoreboard #(.NW(NW), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .sb(sbif));

  int n_checks = 0;
  int n_errors = 0;

  // reference model: pending sets; counts are popcounts of those sets
  bit m_pend [NW][32];
  int m_phase;   // 0 idle, 1 waiting for drain, 2 completing
  int m_fwarp;
  bit e_done, e_err;
  int e_fwarp;
  bit [NW-1:0] e_busy;

  // values sampled during the most recent cycle
  bit s_stall, s_done, s_err;
  int s_fwarp;
  bit [NW-1:0] s_busy;

  typedef struct {
    bit v; int warp; int s1; int s2; int dest; int wb; bit fence; bit exp_stall;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pc(int w);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[w][r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < NW; w++) for (int r = 0; r < 32; r++) m_pend[w][r] = 1'b0;
    m_phase = 0; m_fwarp = 0; e_done = 0; e_err = 0; e_fwarp = 0; e_busy = '0;
  endtask

  function automatic bit model_stall();
    int w, s1, s2, d, k;
    bit raw, waw, ovf, fb;
    w  = int'(sbif.in_decode_warp_num);
    s1 = int'(sbif.in_decode_src1);
    s2 = int'(sbif.in_decode_src2);
    d  = int'(sbif.in_decode_dest);
    k  = int'(sbif.in_decode_wb);
    raw = (s1 != 0 && m_pend[w][s1]) || (s2 != 0 && m_pend[w][s2]);
    waw = (k != NO_WB) && (d != 0) && m_pend[w][d];
    ovf = (k == MEM) && (pc(w) == MAXCNT);
    fb  = (m_phase == 1) && (w == m_fwarp || sbif.in_decode_is_fence);
    return sbif.in_decode_valid && (raw || waw || ovf || fb);
  endfunction

  task automatic model_step();
    int w, d, ww, wd, old_pc;
    bit iss, hit;
    w  = int'(sbif.in_decode_warp_num);
    d  = int'(sbif.in_decode_dest);
    ww = int'(sbif.in_wb_warp_num);
    wd = int'(sbif.in_wb_dest);
    iss = sbif.in_decode_valid && !model_stall() && !sbif.in_ext_stall;
    old_pc = pc(w);
    hit = sbif.in_wb_valid && m_pend[ww][wd];
    if (iss && int'(sbif.in_decode_wb) == MEM && d != 0) m_pend[w][d] = 1'b1;
    if (hit) m_pend[ww][wd] = 1'b0;
    e_err = sbif.in_wb_valid && !hit;
    for (int v = 0; v < NW; v++) e_busy[v] = (pc(v) != 0);
    e_done = 1'b0;
    if (m_phase == 1) begin
      if (pc(m_fwarp) == 0) begin m_phase = 2; e_done = 1'b1; end
    end else if (iss && sbif.in_decode_is_fence) begin
      m_fwarp = w;
      if (old_pc == 0) begin m_phase = 2; e_done = 1'b1; end
      else m_phase = 1;
    end else begin
      m_phase = 0;
    end
    e_fwarp = m_fwarp;
  endtask

  // one clock cycle: sample and check mid-cycle, advance the model, then
  // return just after the next rising edge so the caller can drive inputs
  task automatic cyc();
    @(negedge clk);
    s_stall = sbif.out_stall;
    s_busy  = sbif.out_warp_busy;
    s_done  = sbif.out_fence_done;
    s_fwarp = int'(sbif.out_fence_warp);
    s_err   = sbif.out_wb_err;
    chk("model_stall", int'(s_stall), int'(model_stall()));
    chk("model_busy", int'(s_busy), int'(e_busy));
    chk("model_fence_done", int'(s_done), int'(e_done));
    chk("model_wb_err", int'(s_err), int'(e_err));
    if (e_done) chk("model_fence_warp", s_fwarp, e_fwarp);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(bit v, int w, int s1, int s2, int d, int k, bit f, bit ext);
    sbif.in_decode_valid    = v;
    sbif.in_decode_warp_num = NWB'(w);
    sbif.in_decode_src1     = 5'(s1);
    sbif.in_decode_src2     = 5'(s2);
    sbif.in_decode_dest     = 5'(d);
    sbif.in_decode_wb       = 2'(k);
    sbif.in_decode_is_fence = f;
    sbif.in_ext_stall       = ext;
  endtask

  task automatic wbk(bit v, int w, int d);
    sbif.in_wb_valid    = v;
    sbif.in_wb_warp_num = NWB'(w);
    sbif.in_wb_dest     = 5'(d);
  endtask

  task automatic idle();
    dec(1'b0, 0, 0, 0, 0, NO_WB, 1'b0, 1'b0);
    wbk(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    idle();
    do_reset();

    // reset state
    cyc();
    chk("reset_stall", int'(s_stall), 0);
    chk("reset_busy", int'(s_busy), 0);
    chk("reset_done", int'(s_done), 0);
    chk("reset_err", int'(s_err), 0);

    // load hazard: warp 2 load to x5, dependent read held until writeback
    dec(1, 2, 0, 0, 5, MEM, 0, 0); cyc();
    chk("lh_t0_stall", int'(s_stall), 0);
    chk("lh_t0_busy", int'(s_busy[2]), 0);
    dec(1, 2, 5, 0, 6, ALU, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      if (t == 4) wbk(1, 2, 5);
      cyc();
      chk("lh_stall_held", int'(s_stall), 1);
      chk("lh_busy_held", int'(s_busy[2]), 1);
    end
    wbk(0, 0, 0); cyc();
    chk("lh_t5_release", int'(s_stall), 0);
    chk("lh_t5_busy", int'(s_busy[2]), 0);
    idle(); cyc();

    // table setup: w2:x5, w0:x7, w1:x1..x3 (warp 1 at max count)
    dec(1, 2, 0, 0, 5, MEM, 0, 0); cyc();
    dec(1, 0, 0, 0, 7, MEM, 0, 0); cyc();
    for (int r = 1; r <= 3; r++) begin dec(1, 1, 0, 0, r, MEM, 0, 0); cyc(); end
    tbl[0]  = '{1'b1, 3, 5, 0, 8, ALU,   1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2, 5, 0, 8, ALU,   1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2, 0, 5, 8, ALU,   1'b0, 1'b1};
    tbl[3]  = '{1'b1, 2, 6, 4, 5, ALU,   1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2, 6, 4, 5, NO_WB, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 0, 0, 0, 7, ALU,   1'b0, 1'b1};
    tbl[6]  = '{1'b1, 0, 0, 0, 7, JAL,   1'b0, 1'b1};
    tbl[7]  = '{1'b1, 0, 0, 0, 0, MEM,   1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1, 0, 0, 9, MEM,   1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1, 4, 0, 9, ALU,   1'b0, 1'b0};
    tbl[10] = '{1'b1, 1, 2, 0, 9, ALU,   1'b0, 1'b1};
    tbl[11] = '{1'b0, 0, 7, 0, 0, ALU,   1'b0, 1'b0};
    tbl[12] = '{1'b1, 0, 0, 0, 0, NO_WB, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      dec(tbl[i].v, tbl[i].warp, tbl[i].s1, tbl[i].s2, tbl[i].dest, tbl[i].wb, tbl[i].fence, 1'b1);
      cyc();
      chk($sformatf("tbl_stall_%0d", i), int'(s_stall), int'(tbl[i].exp_stall));
    end

    // load to x0 issues without counting: one writeback of x7 empties warp 0
    dec(1, 0, 0, 0, 0, MEM, 0, 0); cyc();
    chk("x0_mem_issue", int'(s_stall), 0);
    idle(); wbk(1, 0, 7); cyc();
    wbk(0, 0, 0); cyc();
    chk("x0_count_unchanged", int'(s_busy[0]), 0);

    // overflow: 4th load on warp 1 waits for a writeback
    dec(1, 1, 0, 0, 4, MEM, 0, 0); cyc();
    chk("ovf_stall", int'(s_stall), 1);
    cyc();
    chk("ovf_stall2", int'(s_stall), 1);
    wbk(1, 1, 2); cyc();
    chk("ovf_wb_cycle", int'(s_stall), 1);
    wbk(0, 0, 0); cyc();
    chk("ovf_release", int'(s_stall), 0);
    idle(); cyc();

    // writeback to a non-pending register
    wbk(1, 0, 9); cyc();
    chk("wb_err_before", int'(s_err), 0);
    wbk(0, 0, 0); cyc();
    chk("wb_err_pulse", int'(s_err), 1);
    cyc();
    chk("wb_err_one_cycle", int'(s_err), 0);

    // fence drain on warp 4 with two loads in flight
    do_reset();
    dec(1, 4, 0, 0, 1, MEM, 0, 0); cyc();
    dec(1, 4, 0, 0, 2, MEM, 0, 0); cyc();
    dec(1, 4, 0, 0, 0, NO_WB, 1, 0); cyc();
    chk("fd_t0_issue", int'(s_stall), 0);
    dec(1, 4, 0, 0, 9, ALU, 0, 0); cyc();
    chk("fd_t1_same_warp_held", int'(s_stall), 1);
    dec(1, 6, 0, 0, 9, ALU, 0, 0); cyc();
    chk("fd_t2_other_warp_alu", int'(s_stall), 0);
    dec(1, 6, 0, 0, 0, NO_WB, 1, 0);
    for (int t = 3; t <= 6; t++) begin
      if (t == 3) wbk(1, 4, 1);
      else if (t == 6) wbk(1, 4, 2);
      else wbk(0, 0, 0);
      cyc();
      chk("fd_other_fence_held", int'(s_stall), 1);
      chk("fd_no_early_done", int'(s_done), 0);
    end
    wbk(0, 0, 0); cyc();
    chk("fd_t7_done", int'(s_done), 1);
    chk("fd_t7_warp", s_fwarp, 4);
    chk("fd_t7_fence6_issue", int'(s_stall), 0);
    idle(); cyc();
    chk("fd_t8_done", int'(s_done), 1);
    chk("fd_t8_warp", s_fwarp, 6);
    cyc();
    chk("fd_t9_quiet", int'(s_done), 0);

    // reset while draining
    dec(1, 5, 0, 0, 3, MEM, 0, 0); cyc();
    dec(1, 5, 0, 0, 0, NO_WB, 1, 0); cyc();
    idle(); cyc();
    chk("rd_busy_before", int'(s_busy[5]), 1);
    do_reset();
    dec(1, 5, 3, 0, 8, ALU, 0, 0); cyc();
    chk("rd_stall_cleared", int'(s_stall), 0);
    chk("rd_busy_cleared", int'(s_busy), 0);
    chk("rd_no_done", int'(s_done), 0);
    idle();
    repeat (3) begin
      cyc();
      chk("rd_no_done_later", int'(s_done), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      dec(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
      wbk(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      cyc();
    end
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
